// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: time-shares one 16x16 signed multiplier into a wide accumulator.
// Optional MAC_SAT_EN clamps the result to signed 32-bit range and flags out_sat.
module mac_seq_ctrl #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic signed [31:0]       prod_r_q, prod_r_d;
    logic                     prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [31:0]       mult_c;
    logic signed [ACC_W-1:0]  res_data_c;
    logic                     res_sat_c;

    assign mult_c = $signed(in_a) * $signed(in_b);

    // Final result as presented on the output port
`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sd2147483647);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-64'sd2147483648);

    always_comb begin
        res_data_c = acc_q;
        res_sat_c  = 1'b0;
        if (acc_q > SAT_MAX) begin
            res_data_c = SAT_MAX;
            res_sat_c  = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            res_data_c = SAT_MIN;
            res_sat_c  = 1'b1;
        end
    end
`else
    always_comb begin
        res_data_c = acc_q;
        res_sat_c  = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prod_r_d   = prod_r_q;
        prod_v_d   = 1'b0;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        if (prod_v_q) begin
            acc_d = acc_q + ACC_W'(prod_r_q);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = RUN;
                    end else begin
                        out_data_d = '0;
                        out_sat_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    prod_r_d = mult_c;
                    prod_v_d = 1'b1;
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave only once the product stage is empty so acc is final
                if (!prod_v_q) begin
                    out_data_d = res_data_c;
                    out_sat_d  = res_sat_c;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == RUN);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prod_r_q    <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_r_q    <= prod_r_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
